// File: rtl/rsa_modexp_ctrl_if.sv
// Bundle between the RSA modexp controller, its host, and the Montgomery multiplier.
// master = host plus multiplier side, slave = controller side.
interface rsa_modexp_ctrl_if #(
  parameter int BITS     = 128,
  parameter int EXP_BITS = 128
);
  logic                start;
  logic [BITS-1:0]     msg;
  logic [EXP_BITS-1:0] exp;
  logic [BITS-1:0]     mod;
  logic [BITS-1:0]     r2;
  logic                busy;
  logic                done;
  logic [BITS-1:0]     result;
  logic                mm_go;
  logic [BITS-1:0]     mm_a;
  logic [BITS-1:0]     mm_b;
  logic [BITS-1:0]     mm_m;
  logic                mm_done;
  logic [BITS-1:0]     mm_s;

  modport master (
    output start, msg, exp, mod, r2, mm_done, mm_s,
    input  busy, done, result, mm_go, mm_a, mm_b, mm_m
  );

  modport slave (
    input  start, msg, exp, mod, r2, mm_done, mm_s,
    output busy, done, result, mm_go, mm_a, mm_b, mm_m
  );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply modexp controller driving an external Montgomery multiplier.
// Optional macro MODEXP_SKIP_LEADING_ZEROS_EN skips squaring over the leading zero bits of exp.
module rsa_modexp_ctrl #(
  parameter int BITS     = 128,
  parameter int EXP_BITS = 128,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rsa_modexp_ctrl_if.slave  bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_MONT_X, S_MONT_P, S_SCAN, S_SQUARE, S_MULT, S_NEXT, S_FROM_MONT, S_DONE
  } state_t;
  typedef enum logic [1:0] {M_ISSUE, M_WAIT, M_DRAIN} sub_t;

  localparam logic [BITS-1:0]  ONE     = BITS'(1);
  localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(EXP_BITS - 1);

  state_t              r_state, w_state_next;
  sub_t                r_sub, w_sub_next;
  logic                r_drain, w_drain_next;
  logic [BITS-1:0]     r_msg, r_mod, r_r2, r_x, r_p, r_result, r_mm_a, r_mm_b;
  logic [EXP_BITS-1:0] r_exp;
  logic [CNT_W-1:0]    r_idx;
  logic                r_busy, r_done, r_mm_go;

  logic                w_accept, w_issue, w_capture, w_mul_end, w_idx_dec, w_p_from_x, w_finish;
  logic                w_mul_state;
  logic [BITS-1:0]     w_op_a, w_op_b;
  logic [EXP_BITS-1:0] w_exp_shift;
  logic                w_exp_bit;

  assign w_exp_shift = r_exp >> r_idx;
  assign w_exp_bit   = w_exp_shift[0];
  assign w_mul_state = (r_state == S_MONT_X) || (r_state == S_MONT_P) || (r_state == S_SQUARE) ||
                       (r_state == S_MULT) || (r_state == S_FROM_MONT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sub   <= M_ISSUE;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sub   <= w_sub_next;
      r_drain <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sub_next   = r_sub;
    w_drain_next = r_drain;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_mul_end    = 1'b0;
    w_idx_dec    = 1'b0;
    w_p_from_x   = 1'b0;
    w_finish     = 1'b0;
    w_op_a       = r_p;
    w_op_b       = r_p;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_accept     = 1'b1;
        w_state_next = S_MONT_X;
      end
      S_MONT_X:    begin w_op_a = r_msg; w_op_b = r_r2; end
      S_MONT_P:    begin w_op_a = ONE;   w_op_b = r_r2; end
      S_MULT:      w_op_b = r_x;
      S_FROM_MONT: w_op_b = ONE;
      S_NEXT: begin
        if (r_idx == '0) begin
          w_state_next = S_FROM_MONT;
        end else begin
          w_idx_dec    = 1'b1;
          w_state_next = S_SQUARE;
        end
      end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      S_SCAN: begin
        // The first set bit needs no square or multiply: 1^2*X is just X.
        if (w_exp_bit) begin
          w_p_from_x   = 1'b1;
          w_state_next = S_NEXT;
        end else if (r_idx == '0) begin
          w_state_next = S_FROM_MONT;
        end else begin
          w_idx_dec = 1'b1;
        end
      end
`endif
      S_DONE:  w_state_next = S_IDLE;
      default: ;
    endcase

    // Drain keeps mm_go low two cycles and until the multiplier has cleared done.
    if (w_mul_state) begin
      case (r_sub)
        M_ISSUE: if (!bus.mm_done) begin
          w_issue    = 1'b1;
          w_sub_next = M_WAIT;
        end
        M_WAIT: if (bus.mm_done) begin
          w_capture    = 1'b1;
          w_drain_next = 1'b0;
          w_sub_next   = M_DRAIN;
        end
        M_DRAIN: begin
          w_drain_next = 1'b1;
          if (r_drain && !bus.mm_done) begin
            w_mul_end  = 1'b1;
            w_sub_next = M_ISSUE;
          end
        end
        default: w_sub_next = M_ISSUE;
      endcase
    end

    if (w_mul_end) begin
      case (r_state)
        S_MONT_X: w_state_next = S_MONT_P;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        S_MONT_P: w_state_next = S_SCAN;
`else
        S_MONT_P: w_state_next = S_SQUARE;
`endif
        S_SQUARE: w_state_next = w_exp_bit ? S_MULT : S_NEXT;
        S_MULT:   w_state_next = S_NEXT;
        S_FROM_MONT: begin
          w_state_next = S_DONE;
          w_finish     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_msg <= '0; r_exp <= '0; r_mod <= '0; r_r2 <= '0;
      r_x <= '0; r_p <= '0; r_result <= '0; r_idx <= '0;
      r_mm_a <= '0; r_mm_b <= '0; r_mm_go <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_msg  <= bus.msg;
        r_exp  <= bus.exp;
        r_mod  <= bus.mod;
        r_r2   <= bus.r2;
        r_busy <= 1'b1;
      end
      if (w_issue) begin
        r_mm_a  <= w_op_a;
        r_mm_b  <= w_op_b;
        r_mm_go <= 1'b1;
      end
      if (w_capture) begin
        r_mm_go <= 1'b0;
        if (r_state == S_MONT_X) r_x <= bus.mm_s;
        else                     r_p <= bus.mm_s;
      end
      if (w_p_from_x) r_p <= r_x;
      if (w_mul_end && (r_state == S_MONT_P)) r_idx <= TOP_IDX;
      else if (w_idx_dec)                     r_idx <= r_idx - CNT_W'(1);
      if (w_finish) begin
        r_result <= r_p;
        r_busy   <= 1'b0;
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.mm_go  = r_mm_go;
  assign bus.mm_a   = r_mm_a;
  assign bus.mm_b   = r_mm_b;
  assign bus.mm_m   = r_mod;
endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
- Initiator for the team's Montgomery multiplier. It drives that block's go/done handshake, issuing operands and capturing results.
- Computes result = msg^exp mod M by left-to-right square-and-multiply in the Montgomery domain.
- Sits between the RSA top-level register interface and one external Montgomery multiplier instance.
- The multiplier computes S = A*B*2^-BITS mod M and returns S < M.

Parameters:
- BITS, 128, operand width; must match the multiplier's width.
- EXP_BITS, 128, exponent width scanned by the controller.
- CNT_W, 8, width of the exponent bit index; must satisfy 2^CNT_W > EXP_BITS.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; synchronous and active-low
- start  in  1  one-cycle request; sampled only in IDLE
- msg  in  BITS  base; must be < mod
- exp  in  EXP_BITS  exponent
- mod  in  BITS  modulus; must be odd
- r2  in  BITS  precomputed 2^(2*BITS) mod M
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when result is valid
- result  out  BITS  msg^exp mod M; held until the next accepted start
- mm_go  out  1  level request to the multiplier
- mm_a  out  BITS  multiplier operand A; stable while mm_go=1
- mm_b  out  BITS  multiplier operand B; stable while mm_go=1
- mm_m  out  BITS  latched modulus
- mm_done  in  1  multiplier completion level
- mm_s  in  BITS  multiplier result; valid while mm_done=1

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - busy=0, done=0, result=0, mm_go=0, mm_a=0, mm_b=0, mm_m=0.
  - Main FSM goes to IDLE and the index is cleared.
  - Reset mid-operation abandons the computation. mm_go drops on the same edge, which returns the multiplier to its reset state.
- Operand latch: start in IDLE latches msg, exp, mod and r2 into internal registers. Inputs may change afterwards. start outside IDLE is ignored.
- Multiply sub-sequence, used for every multiply:
  - ISSUE: drive mm_a and mm_b, set mm_go=1.
  - WAIT: hold until mm_done=1, then capture mm_s into the destination register and set mm_go=0.
  - DRAIN: hold mm_go=0 for at least 2 cycles and until mm_done=0. The multiplier needs one cycle to enter reset and one more to clear done.
  - Then return to the main FSM.
  - mm_go never rises while mm_done=1.
- Main FSM states:
  - IDLE: on start, go to MONT_X with busy=1.
  - MONT_X: X = MM(msg, r2), putting msg into the Montgomery domain.
  - MONT_P: P = MM(1, r2) = R mod M; index = EXP_BITS-1.
  - SQUARE: P = MM(P, P). If exp[index]=1 go to MULT, else go to NEXT.
  - MULT: P = MM(P, X); go to NEXT.
  - NEXT: if index==0 go to FROM_MONT; else decrement index and go to SQUARE.
  - FROM_MONT: P = MM(P, 1).
  - DONE: result <= P, done=1 for one cycle, busy=0, go to IDLE.
- Each main-FSM transition is registered: one cycle per state, plus the sub-sequence cycles.
- Multiply count without the optional feature: 3 + EXP_BITS + popcount(exp).
- Width rules:
  - All values are BITS wide. The constant 1 is zero-extended.
  - No arithmetic beyond index decrement; all modular work is done by the multiplier.
- Boundary cases:
  - exp=0 gives result=1 (for M>1).
  - msg=0 with exp>0 gives result=0.
  - index wrap at 0 is prevented by the NEXT check.
  - start and done in the same cycle: start is ignored, because the FSM is not yet in IDLE.

Optional Feature:
- Macro: MODEXP_SKIP_LEADING_ZEROS_EN
- With the macro defined: after MONT_P, the FSM scans exp from the MSB in a SCAN state, at one bit per cycle with no multiply, while the bit is 0.
  - At the first 1 it sets P=X and continues at NEXT, skipping that bit's square and multiply.
  - If exp=0, it goes to FROM_MONT with P = R mod M.
  - Multiply count becomes 3 + (msb_pos) + popcount(exp) - 1.
- Without the macro: all EXP_BITS bits are squared unconditionally. Timing is exponent-value independent except for MULT steps.
- Results are identical either way.

Test Plan:
- M=187, msg=88, exp=7, r2 from bench model -> result=11, done pulses once, busy low afterwards.
- M=187, msg=11, exp=23 -> result=88 (decrypt round trip).
- exp=0, msg=88, M=187 -> result=1; exp=1 -> result=88; msg=0, exp=5 -> result=0.
- Multiplier model with random done delay (1-400 cycles); check the handshake:
  - mm_go never rises while mm_done=1.
  - mm_go is low for at least 2 cycles between operations.
  - mm_a and mm_b are stable while mm_go=1.
  - Multiply count equals the formula for the configured macro.
- rst_n=0 asserted mid-SQUARE -> next cycle mm_go=0, busy=0, done=0, result=0. A new start with M=187, msg=88, exp=7 -> result=11.
- start pulsed while busy with different operands -> ignored; original result returned.
